// File: rtl/sd_pkg.sv
// Shared definitions for the signed-digit to binary converter:
// FSM state encoding and default sizing constants.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } sd_state_t;

  localparam int unsigned SD_DEF_WIDTH  = 32;
  localparam int unsigned SD_DEF_CHUNK  = 8;
  localparam int unsigned SD_DEF_NCHUNK = SD_DEF_WIDTH / SD_DEF_CHUNK;

endpackage

// File: rtl/sd_chunk_sub.sv
// Combinational CHUNK-bit subtractor: diff = p - n - borrow_in, with borrow out.
module sd_chunk_sub #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] p,
  input  logic [CHUNK-1:0] n,
  input  logic             borrow_in,
  output logic [CHUNK-1:0] diff,
  output logic             borrow_out
);

  logic [CHUNK:0] full;

  // Zero-extended subtraction: the extra MSB wraps to 1 exactly when a borrow occurs.
  always_comb begin
    full = {1'b0, p} - {1'b0, n} - {{CHUNK{1'b0}}, borrow_in};
  end

  assign diff       = full[CHUNK-1:0];
  assign borrow_out = full[CHUNK];

endmodule

// File: rtl/sd_to_bin_converter.sv
// Converts a two-rail signed-digit operand (in_p - in_n) to two's complement,
// resolving CHUNK digits per cycle with one shared chunk subtractor.
module sd_to_bin_converter
  import sd_pkg::*;
#(
  parameter int unsigned WIDTH = SD_DEF_WIDTH,
  parameter int unsigned CHUNK = SD_DEF_CHUNK
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WIDTH:0] out_bin
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  sd_state_t        state;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH:0]   result;
  logic             borrow;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] p_chunk;
  logic [CHUNK-1:0] n_chunk;
  logic [CHUNK-1:0] diff;
  logic             borrow_out;

  always_comb begin
    p_chunk = '0;
    n_chunk = '0;
    for (int unsigned k = 0; k < NCHUNK; k++) begin
      if (idx == IDX_W'(k)) begin
        p_chunk = p_q[k*CHUNK +: CHUNK];
        n_chunk = n_q[k*CHUNK +: CHUNK];
      end
    end
  end

  sd_chunk_sub #(
    .CHUNK (CHUNK)
  ) u_chunk_sub (
    .p          (p_chunk),
    .n          (n_chunk),
    .borrow_in  (borrow),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      p_q    <= '0;
      n_q    <= '0;
      result <= '0;
      borrow <= 1'b0;
      idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_q    <= in_p;
            n_q    <= in_n;
            result <= '0;
            borrow <= 1'b0;
            idx    <= '0;
            state  <= CONV;
          end
        end
        CONV: begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (idx == IDX_W'(k)) result[k*CHUNK +: CHUNK] <= diff;
          end
          borrow <= borrow_out;
          if (idx == LAST_IDX) begin
            // Final borrow is the sign bit of the WIDTH+1 bit result.
            result[WIDTH] <= borrow_out;
            state         <= HOLD;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == HOLD);
  assign out_bin   = (state == HOLD) ? result : '0;

endmodule

// File: tb/tb_sd_to_bin_converter.sv
// Directed self-checking bench for sd_to_bin_converter at WIDTH=32, CHUNK=8.
module tb_sd_to_bin_converter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_p;
  logic [31:0] in_n;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_bin;

  int tests;
  int fails;

  sd_to_bin_converter #(
    .WIDTH (32),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operand end to end: accept, count latency, hold for hold_cycles, release.
  task automatic run_op(input string tag, input logic [31:0] p, input logic [31:0] n,
                        input logic [32:0] exp, input int hold, input bit scramble);
    int edges;
    out_ready = (hold == 0);
    @(negedge clk);
    in_p     = p;
    in_n     = n;
    in_valid = 1'b1;
    chk({tag, "_ready_before"}, {32'd0, in_ready}, 33'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 8) begin
      chk({tag, "_conv_bin"}, out_bin, 33'd0);
      chk({tag, "_conv_ready"}, {32'd0, in_ready}, 33'd0);
      if (scramble) begin
        in_p     = $urandom;
        in_n     = $urandom;
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 33'(edges), 33'd4);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, {32'd0, out_valid}, 33'd1);
      chk({tag, "_hold_bin"}, out_bin, exp);
      chk({tag, "_hold_ready"}, {32'd0, in_ready}, 33'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk({tag, "_bin"}, out_bin, exp);
    chk({tag, "_valid"}, {32'd0, out_valid}, 33'd1);
    @(posedge clk); #1;
    chk({tag, "_done_valid"}, {32'd0, out_valid}, 33'd0);
    chk({tag, "_done_ready"}, {32'd0, in_ready}, 33'd1);
    chk({tag, "_done_bin"}, out_bin, 33'd0);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_p      = '0;
    in_n      = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_ready", {32'd0, in_ready}, 33'd0);
    chk("rst_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_bin", out_bin, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", {32'd0, in_ready}, 33'd1);

    run_op("ff_minus_1", 32'h0000_00FF, 32'h0000_0001, 33'h0_0000_00FE, 0, 1'b0);
    run_op("most_neg",   32'h0000_0000, 32'hFFFF_FFFF, 33'h1_0000_0001, 0, 1'b0);
    run_op("most_pos",   32'hFFFF_FFFF, 32'h0000_0000, 33'h0_FFFF_FFFF, 0, 1'b0);
    run_op("ripple",     32'h1000_0000, 32'h0000_0001, 33'h0_0FFF_FFFF, 0, 1'b0);
    run_op("equal_a5",   32'hA5A5_A5A5, 32'hA5A5_A5A5, 33'h0,           10, 1'b0);
    run_op("stall_nz",   32'h1234_5678, 32'h0F0F_0F0F, 33'h0_0325_4769, 5, 1'b0);

    // Reset two edges into CONV must discard the operand.
    out_ready = 1'b1;
    @(negedge clk);
    in_p     = 32'hDEAD_BEEF;
    in_n     = 32'h0000_0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {32'd0, out_valid}, 33'd0);
    chk("midrst_ready", {32'd0, in_ready}, 33'd0);
    chk("midrst_bin", out_bin, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", {32'd0, in_ready}, 33'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", {32'd0, out_valid}, 33'd0);
    end
    run_op("five_minus_7", 32'h0000_0005, 32'h0000_0007, 33'h1_FFFF_FFFE, 0, 1'b0);

    run_op("scramble", 32'h8000_0001, 32'h7FFF_FFFF, 33'h0_0000_0002, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sd_to_bin_converter.md
SD_TO_BIN_CONVERTER -- requirements
Module: sd_to_bin_converter

Interface
REQ-001 Parameter WIDTH, default 32: number of signed digits in the operand and result magnitude.
REQ-002 Parameter CHUNK, default 8: digits resolved per conversion cycle; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1: upstream offers an operand.
REQ-006 in_ready  output  1: block can accept an operand.
REQ-007 in_p  input  WIDTH: positive-rail bits of the hybrid signed-digit operand (adder tp/um-style rail output).
REQ-008 in_n  input  WIDTH: negative-rail bits; digit i value = in_p[i] - in_n[i], both set = 0 (legal).
REQ-009 out_valid  output  1: out_bin holds a converted result.
REQ-010 out_ready  input  1: downstream accepts the result.
REQ-011 out_bin  output  WIDTH+1: two's-complement value of the operand, sum of (in_p - in_n) * 2^i.

Function
REQ-012 Conversion SHALL compute out_bin = in_p - in_n with WIDTH+1 bits; range -(2^WIDTH-1) to +(2^WIDTH-1), no overflow possible, no saturation.
REQ-013 FSM states SHALL be IDLE, CONV, HOLD; in_ready = 1 only in IDLE, out_valid = 1 only in HOLD.
REQ-014 IDLE: on in_valid & in_ready at an edge, register in_p and in_n, clear borrow and chunk index, go to CONV; otherwise stay.
REQ-015 Inputs SHALL be sampled only at the accepting edge; later changes on in_p, in_n or in_valid SHALL not affect the result.
REQ-016 CONV: each edge subtracts chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) of P and N, LSB chunk first, with incoming borrow; writes the CHUNK-bit difference into result chunk k and registers the borrow out.
REQ-017 After the last chunk (index WIDTH/CHUNK-1), out_bin[WIDTH] SHALL be set to the final borrow and the FSM SHALL go to HOLD.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH/CHUNK edges after the accepting edge (4 edges at default parameters).
REQ-019 HOLD: out_bin and out_valid SHALL remain stable while out_ready = 0, with no timeout.
REQ-020 HOLD: on out_valid & out_ready at an edge, go to IDLE; in_ready rises in the following cycle, so there is no same-cycle result/accept overlap.
REQ-021 Throughput: one operand per WIDTH/CHUNK + 2 cycles when out_ready is held high.
REQ-022 out_bin SHALL be 0 whenever not in HOLD.
REQ-023 Operand with in_p = in_n (any value) SHALL yield 0.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, out_valid 0, out_bin 0, borrow 0, index 0, and captured operands 0.
REQ-025 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-026 Reset during CONV or HOLD SHALL discard the operation; no partial result ever reaches out_valid = 1.

Structure
REQ-027 Shared package sd_pkg SHALL hold the state enum (IDLE/CONV/HOLD), default WIDTH/CHUNK constants, and the chunk-count constant WIDTH/CHUNK.
REQ-028 One combinational sub-module sd_chunk_sub (CHUNK-bit P - N - borrow_in -> diff, borrow_out) SHALL be instantiated once and time-multiplexed over chunks.
REQ-029 Chunk index counter width SHALL be clog2(WIDTH/CHUNK), minimum 1 bit.

Verification (WIDTH=32, CHUNK=8)
REQ-030 in_p=0x000000FF, in_n=0x00000001 -> out_valid 4 edges after accept, out_bin=33'h0_000000FE.
REQ-031 in_p=0x00000000, in_n=0xFFFFFFFF -> out_bin=33'h1_00000001 (-(2^32-1)).
REQ-032 Borrow ripple through all chunks: in_p=0x10000000, in_n=0x00000001 -> out_bin=33'h0_0FFFFFFF.
REQ-033 in_p=in_n=0xA5A5A5A5 -> out_bin=0; then out_ready held 0 for 10 cycles -> out_valid stays 1, out_bin stable, in_ready 0; out_ready=1 -> IDLE, in_ready=1 the following cycle.
REQ-034 rst_n pulsed low after 2 CONV edges -> out_valid never rises for that operand; in_ready=1 after release; next operand in_p=0x00000005, in_n=0x00000007 -> out_bin=33'h1_FFFFFFFE.
REQ-035 in_p/in_n changed every cycle during CONV -> result matches the values captured at the accepting edge.
